sync_aligner: RTL

//  Receive-side partner of the transmit sync insertion logic on the off-chip link.

---
 rtl/sync_pkg.sv | 16 +
 rtl/sync_aligner_if.sv | 26 ++
 rtl/sync_slot_counter.sv | 37 +++
 rtl/sync_aligner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// sync_pkg: shared types and constants for the receive-side sync aligner.
//   state_e       : HUNT / VERIFY / LOCKED frame-lock states
//   SYNC_WORD_DEF : default sync pattern inserted by the transmit side
//   CNT_W         : slot counter width (FREQ is at most 63)
package sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
    localparam int          CNT_W         = 6;

endpackage

// File: rtl/sync_aligner_if.sv
// sync_aligner_if: word stream in, stripped data stream and lock status out.
//   master : drives resync/word_valid/word_in, observes outputs (link-side source)
//   slave  : the aligner itself
interface sync_aligner_if #(
    parameter int WIDTH = 16
);
    logic             resync;
    logic             word_valid;
    logic [WIDTH-1:0] word_in;
    logic             data_valid;
    logic [WIDTH-1:0] data_out;
    logic             locked;
    logic             sync_ok;
    logic             sync_err;
    logic [7:0]       err_count;

    modport master (
        output resync, word_valid, word_in,
        input  data_valid, data_out, locked, sync_ok, sync_err, err_count
    );

    modport slave (
        input  resync, word_valid, word_in,
        output data_valid, data_out, locked, sync_ok, sync_err, err_count
    );
endinterface

// File: rtl/sync_slot_counter.sv
// sync_slot_counter: position of the current word within a sync period.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : force count to 0 (highest priority)
//   adv_i      : advance on an accepted word; wraps to 0 after the sync slot
//   at_slot_o  : count equals FREQ, i.e. the current word is the sync slot
module sync_slot_counter
    import sync_pkg::*;
#(
    parameter int FREQ = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic adv_i,
    output logic at_slot_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign at_slot_o = (cnt_q == CNT_W'(FREQ));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = at_slot_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sync_aligner.sv
// sync_aligner: acquires and holds frame lock on a periodic sync word and
// forwards only the data words (sync slots stripped) once locked.
//   clk, rst_n : clock, async active-low reset
//   bus        : sync_aligner_if.slave (resync, word_valid, word_in in;
//                data_valid, data_out, locked, sync_ok, sync_err, err_count out)
// Optional feature macro: SYNC_ERR_CNT_EN adds a saturating 8-bit miss counter
// on err_count (cleared only by rst_n); without it err_count is tied to zero.
//
//  state  | meaning
//  HUNT   | searching for any sync word
//  VERIFY | sync seen, checking that further syncs arrive FREQ words apart
//  LOCKED | frame locked, data words forwarded, sync slots monitored
module sync_aligner
    import sync_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(SYNC_WORD_DEF),
    parameter int               FREQ       = 16,
    parameter int               LOCK_CNT   = 2,
    parameter int               UNLOCK_CNT = 3
) (
    input logic           clk,
    input logic           rst_n,
    sync_aligner_if.slave bus
);
    state_e           state_q;
    logic [2:0]       hits_q;
    logic [2:0]       misses_q;
    logic             data_valid_q;
    logic [WIDTH-1:0] data_out_q;
    logic             locked_q;
    logic             sync_ok_q;
    logic             sync_err_q;

    logic accept;
    logic is_sync;
    logic at_slot;
    logic miss_evt;

    // resync swallows a word presented in the same cycle
    assign accept   = bus.word_valid && !bus.resync;
    assign is_sync  = (bus.word_in == SYNC_WORD);
    assign miss_evt = accept && (state_q == LOCKED) && at_slot && !is_sync;

    // HUNT keeps the counter parked at 0 so the first sync starts a fresh period
    sync_slot_counter #(.FREQ(FREQ)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (bus.resync || (state_q == HUNT)),
        .adv_i     (bus.word_valid),
        .at_slot_o (at_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            hits_q       <= '0;
            misses_q     <= '0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            locked_q     <= 1'b0;
            sync_ok_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sync_ok_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            if (bus.resync) begin
                state_q  <= HUNT;
                hits_q   <= '0;
                misses_q <= '0;
                locked_q <= 1'b0;
            end else if (accept) begin
                case (state_q)
                    HUNT: begin
                        if (is_sync) begin
                            state_q <= VERIFY;
                            hits_q  <= 3'd1;
                        end
                    end
                    VERIFY: begin
                        if (at_slot) begin
                            if (is_sync) begin
                                hits_q <= hits_q + 3'd1;
                                if (hits_q + 3'd1 == 3'(LOCK_CNT)) begin
                                    state_q  <= LOCKED;
                                    misses_q <= '0;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                state_q <= HUNT;
                                hits_q  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!at_slot) begin
                            // a sync pattern in a data slot is ordinary payload
                            data_valid_q <= 1'b1;
                            data_out_q   <= bus.word_in;
                        end else if (is_sync) begin
                            sync_ok_q <= 1'b1;
                            misses_q  <= '0;
                        end else begin
                            // flywheel: keep slot timing, count the miss
                            sync_err_q <= 1'b1;
                            misses_q   <= misses_q + 3'd1;
                            if (misses_q + 3'd1 == 3'(UNLOCK_CNT)) begin
                                state_q  <= HUNT;
                                hits_q   <= '0;
                                misses_q <= '0;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        hits_q   <= '0;
                        misses_q <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SYNC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (miss_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'd0;
`endif

    assign bus.data_valid = data_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.locked     = locked_q;
    assign bus.sync_ok    = sync_ok_q;
    assign bus.sync_err   = sync_err_q;

    // miss_evt feeds err_count only when the counter exists
    logic unused_miss;
    assign unused_miss = miss_evt;
endmodule
